// File: rtl/ssg_emb_sd_adc_pkg.sv
// Shared constants and encodings for the sigma-delta ADC integrator channel.
package ssg_emb_sd_adc_pkg;

  localparam int ACC_W  = 22;
  localparam int M8     = 8;
  localparam int M16    = 16;
  localparam int DCNT_W = $clog2(M16);

  typedef enum logic {
    DEC_M16 = 1'b0,
    DEC_M8  = 1'b1
  } dec_rate_e;

  // Last decimation-counter value of a frame for the given rate.
  function automatic logic [DCNT_W-1:0] dec_last(input dec_rate_e r);
    return (r == DEC_M8) ? DCNT_W'(M8 - 1) : DCNT_W'(M16 - 1);
  endfunction

endpackage

// File: rtl/ssg_emb_sd_adc_mclk_gen.sv
// Modulator clock divider: produces mclk_out and a one-cycle bit_strobe per modulator bit.
module ssg_emb_sd_adc_mclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic mclk_out,
  output logic bit_strobe
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             mclk_q, mclk_d;

  // mclk is registered from the next divider value so it stays glitch-free.
  always_comb begin
    div_cnt_d = '0;
    if (enable && (div_cnt_q != DIV_LAST)) div_cnt_d = div_cnt_q + DIV_W'(1);
    mclk_d = (div_cnt_d >= DIV_HALF);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      mclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      mclk_q    <= mclk_d;
    end
  end

  assign mclk_out   = mclk_q;
  assign bit_strobe = enable && (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/ssg_emb_sd_adc_integ.sv
// Sigma-delta ADC channel front end: bit synchroniser, third-order integrator,
// decimation timing and stuck-modulator detection.
module ssg_emb_sd_adc_integ
  import ssg_emb_sd_adc_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int FAULT_LEN = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             dec_rate,
  input  logic             mdat,
  input  logic             fault_clr,
  output logic             mclk_out,
  output logic [ACC_W-1:0] cn_out,
  output logic             cnr16,
  output logic             mod_fault
);

  localparam int               RUN_W   = $clog2(FAULT_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FAULT_LEN);

  function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] v);
    return (v == RUN_MAX) ? v : v + RUN_W'(1);
  endfunction

  logic              bit_strobe;
  logic [1:0]        sync_q;
  logic              mdat_s;
  logic [ACC_W-1:0]  acc1_q, acc1_d, acc2_q, acc2_d, acc3_q, acc3_d;
  logic [DCNT_W-1:0] dec_cnt_q, dec_cnt_d;
  dec_rate_e         m_sel_q, m_sel_d;
  logic              en_q, frame_wrap;
  logic              strb_p1_q, vld_p1_q, vld_p2_q;
  logic [ACC_W-1:0]  cn_out_q, cn_out_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d, run_next;
  logic              last_bit_q, last_bit_d;
  logic              mod_fault_q, mod_fault_d, fault_set;

  ssg_emb_sd_adc_mclk_gen #(.CLK_DIV(CLK_DIV)) u_mclk_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .mclk_out   (mclk_out),
    .bit_strobe (bit_strobe)
  );

  assign mdat_s     = sync_q[1];
  assign frame_wrap = bit_strobe && (dec_cnt_q == dec_last(m_sel_q));

  // Stage p0: integrator cascade, frame counter and run-length tracking.
  // Each stage adds the freshly updated upstream sum, so after n ones cn = n(n+1)(n+2)/6.
  always_comb begin
    acc1_d    = acc1_q;
    acc2_d    = acc2_q;
    acc3_d    = acc3_q;
    dec_cnt_d = dec_cnt_q;
    m_sel_d   = m_sel_q;
    if (!enable) begin
      acc1_d    = '0;
      acc2_d    = '0;
      acc3_d    = '0;
      dec_cnt_d = '0;
    end else if (bit_strobe) begin
      acc1_d    = acc1_q + ACC_W'(mdat_s);
      acc2_d    = acc2_q + acc1_d;
      acc3_d    = acc3_q + acc2_d;
      dec_cnt_d = frame_wrap ? '0 : dec_cnt_q + DCNT_W'(1);
    end
    if ((enable && !en_q) || frame_wrap) m_sel_d = dec_rate_e'(dec_rate);

    run_next    = ((run_cnt_q != '0) && (mdat_s == last_bit_q)) ? run_sat_inc(run_cnt_q)
                                                                : RUN_W'(1);
    fault_set   = bit_strobe && (run_next == RUN_MAX);
    run_cnt_d   = fault_clr ? '0 : (bit_strobe ? run_next : run_cnt_q);
    last_bit_d  = bit_strobe ? mdat_s : last_bit_q;
    mod_fault_d = fault_set ? 1'b1 : (fault_clr ? 1'b0 : mod_fault_q);

    cn_out_d = cn_out_q;
    if (!enable)        cn_out_d = '0;
    else if (strb_p1_q) cn_out_d = acc3_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      acc1_q      <= '0;
      acc2_q      <= '0;
      acc3_q      <= '0;
      dec_cnt_q   <= '0;
      m_sel_q     <= DEC_M16;
      en_q        <= 1'b0;
      run_cnt_q   <= '0;
      last_bit_q  <= 1'b0;
      mod_fault_q <= 1'b0;
      strb_p1_q   <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      cn_out_q    <= '0;
    end else begin
      sync_q      <= {sync_q[0], mdat};
      acc1_q      <= acc1_d;
      acc2_q      <= acc2_d;
      acc3_q      <= acc3_d;
      dec_cnt_q   <= dec_cnt_d;
      m_sel_q     <= m_sel_d;
      en_q        <= enable;
      run_cnt_q   <= run_cnt_d;
      last_bit_q  <= last_bit_d;
      mod_fault_q <= mod_fault_d;
      // Stage p1: capture acc3 after the strobe update.
      strb_p1_q   <= bit_strobe;
      vld_p1_q    <= frame_wrap;
      cn_out_q    <= cn_out_d;
      // Stage p2: decimation pulse aligned with the frame's final cn_out.
      vld_p2_q    <= enable && vld_p1_q;
    end
  end

  assign cn_out    = cn_out_q;
  assign cnr16     = vld_p2_q;
  assign mod_fault = mod_fault_q;

endmodule

// File: tb/tb_ssg_emb_sd_adc_integ.sv
// Self-checking bench for ssg_emb_sd_adc_integ with a frame scoreboard.
module tb_ssg_emb_sd_adc_integ;

  localparam int CLK_DIV   = 4;
  localparam int FAULT_LEN = 64;
  localparam int ACC_W     = 22;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             dec_rate = 1'b0;
  logic             mdat = 1'b0;
  logic             fault_clr = 1'b0;
  logic             mclk_out;
  logic [ACC_W-1:0] cn_out;
  logic             cnr16;
  logic             mod_fault;

  ssg_emb_sd_adc_integ #(.CLK_DIV(CLK_DIV), .FAULT_LEN(FAULT_LEN)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .dec_rate  (dec_rate),
    .mdat      (mdat),
    .fault_clr (fault_clr),
    .mclk_out  (mclk_out),
    .cn_out    (cn_out),
    .cnr16     (cnr16),
    .mod_fault (mod_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ACC_W-1:0] cn;
    int               gap;
  } exp_t;

  exp_t             sb[$];
  logic [ACC_W-1:0] cap[$];
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               last_cyc = 0;
  logic [ACC_W-1:0] m1, m2, m3;
  int               mcnt, mm;
  bit               first;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (cnr16 === 1'b1) begin
        exp_t e;
        cap.push_back(cn_out);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cnr16 cn_out=%0d expected no pulse", cn_out);
        end else begin
          e = sb.pop_front();
          if (cn_out !== e.cn) begin
            errors++;
            $display("FAIL frame_cn_out got %0d expected %0d", cn_out, e.cn);
          end
          if (e.gap >= 0) begin
            checks++;
            if ((cyc - last_cyc) != e.gap) begin
              errors++;
              $display("FAIL cnr16_spacing got %0d expected %0d", cyc - last_cyc, e.gap);
            end
          end
        end
        last_cyc = cyc;
      end
    end
  endtask

  task automatic model_clear();
    m1 = '0; m2 = '0; m3 = '0;
    mcnt = 0;
    mm = dec_rate ? 8 : 16;
    first = 1'b1;
  endtask

  task automatic start_run();
    model_clear();
    enable = 1'b1;
  endtask

  // One modulator bit period starting at a negedge; clr_at selects the posedge for fault_clr.
  task automatic send_bit(input logic b, input int clr_at);
    int g;
    mdat = b;
    m1 = m1 + ACC_W'(b);
    m2 = m2 + m1;
    m3 = m3 + m2;
    mcnt++;
    if (mcnt == mm) begin
      g = first ? -1 : mm * CLK_DIV;
      sb.push_back('{m3, g});
      first = 1'b0;
      mcnt = 0;
      mm = dec_rate ? 8 : 16;
    end
    for (int c = 0; c < CLK_DIV; c++) begin
      fault_clr = (c == clr_at);
      @(posedge clk);
      #1;
    end
    fault_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic finish_run();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d expected 0", sb.size());
    end
    sb.delete();
    enable = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 4;
    if (mclk_out !== 1'b0) begin errors++; $display("FAIL rst_mclk got %b expected 0", mclk_out); end
    if (cn_out !== '0) begin errors++; $display("FAIL rst_cn_out got %0d expected 0", cn_out); end
    if (cnr16 !== 1'b0) begin errors++; $display("FAIL rst_cnr16 got %b expected 0", cnr16); end
    if (mod_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b expected 0", mod_fault); end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (mclk_out !== 1'b0) begin errors++; $display("FAIL idle_mclk got %b expected 0", mclk_out); end
  endtask

  task automatic test_fault();
    dec_rate = 1'b1;
    mdat = 1'b0;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    start_run();
    for (int i = 0; i < FAULT_LEN - 1; i++) send_bit(1'b0, -1);
    checks++;
    if (mod_fault !== 1'b0) begin errors++; $display("FAIL fault_early got %b expected 0", mod_fault); end
    send_bit(1'b0, -1);
    checks++;
    if (mod_fault !== 1'b1) begin errors++; $display("FAIL fault_set got %b expected 1", mod_fault); end
    send_bit(1'b0, 0);
    checks++;
    if (mod_fault !== 1'b0) begin errors++; $display("FAIL fault_clr got %b expected 0", mod_fault); end
    for (int i = 0; i < FAULT_LEN - 2; i++) send_bit(1'b0, -1);
    checks++;
    if (mod_fault !== 1'b0) begin errors++; $display("FAIL fault_reearly got %b expected 0", mod_fault); end
    send_bit(1'b0, -1);
    checks++;
    if (mod_fault !== 1'b1) begin errors++; $display("FAIL fault_reset got %b expected 1", mod_fault); end
    send_bit(1'b0, CLK_DIV - 1);
    checks++;
    if (mod_fault !== 1'b1) begin errors++; $display("FAIL fault_set_wins got %b expected 1", mod_fault); end
    send_bit(1'b0, -1);
    checks++;
    if (cn_out !== '0) begin errors++; $display("FAIL zero_cn_out got %0d expected 0", cn_out); end
    finish_run();
    repeat (4) @(negedge clk);
    checks++;
    if (mod_fault !== 1'b1) begin errors++; $display("FAIL fault_hold_disabled got %b expected 1", mod_fault); end
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    checks++;
    if (mod_fault !== 1'b0) begin errors++; $display("FAIL fault_clr_disabled got %b expected 0", mod_fault); end
  endtask

  task automatic test_ones();
    dec_rate = 1'b1;
    cap.delete();
    start_run();
    for (int i = 0; i < 16; i++) send_bit(1'b1, -1);
    finish_run();
    checks++;
    if (cap.size() != 2) begin
      errors++;
      $display("FAIL ones_frames got %0d expected 2", cap.size());
    end else begin
      checks += 2;
      if (cap[0] !== 22'd120) begin errors++; $display("FAIL ones_cn1 got %0d expected 120", cap[0]); end
      if (cap[1] !== 22'd816) begin errors++; $display("FAIL ones_cn2 got %0d expected 816", cap[1]); end
    end
  endtask

  task automatic test_mclk();
    logic exp_m;
    dec_rate = 1'b1;
    mdat = 1'b0;
    start_run();
    for (int i = 0; i < 2 * CLK_DIV; i++) begin
      @(negedge clk);
      exp_m = (((i + 1) % CLK_DIV) >= CLK_DIV / 2);
      checks++;
      if (mclk_out !== exp_m) begin
        errors++;
        $display("FAIL mclk_phase%0d got %b expected %b", i, mclk_out, exp_m);
      end
    end
    enable = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_alternating();
    dec_rate = 1'b0;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    cap.delete();
    start_run();
    for (int i = 0; i < 48; i++) send_bit((i % 2) == 0, -1);
    checks++;
    if (mod_fault !== 1'b0) begin errors++; $display("FAIL alt_fault got %b expected 0", mod_fault); end
    finish_run();
    checks++;
    if (cap.size() != 3) begin errors++; $display("FAIL alt_frames got %0d expected 3", cap.size()); end
  endtask

  task automatic test_wrap();
    longint n;
    logic [ACC_W-1:0] e37, e50;
    dec_rate = 1'b1;
    cap.delete();
    start_run();
    for (int i = 0; i < 400; i++) send_bit(1'b1, -1);
    finish_run();
    n = 296;
    e37 = ACC_W'((n * (n + 1) * (n + 2) / 6) % (longint'(1) << ACC_W));
    n = 400;
    e50 = ACC_W'((n * (n + 1) * (n + 2) / 6) % (longint'(1) << ACC_W));
    checks++;
    if (cap.size() != 50) begin
      errors++;
      $display("FAIL wrap_frames got %0d expected 50", cap.size());
    end else begin
      checks += 2;
      if (cap[36] !== e37) begin errors++; $display("FAIL wrap_cn37 got %0d expected %0d", cap[36], e37); end
      if (cap[49] !== e50) begin errors++; $display("FAIL wrap_cn50 got %0d expected %0d", cap[49], e50); end
    end
  endtask

  task automatic test_rate_change();
    dec_rate = 1'b1;
    cap.delete();
    start_run();
    for (int i = 0; i < 3; i++) send_bit(1'b1, -1);
    dec_rate = 1'b0;
    for (int i = 0; i < 5 + 16; i++) send_bit(1'b1, -1);
    finish_run();
    dec_rate = 1'b1;
    checks++;
    if (cap.size() != 2) begin
      errors++;
      $display("FAIL rate_frames got %0d expected 2", cap.size());
    end else begin
      checks += 2;
      if (cap[0] !== 22'd120) begin errors++; $display("FAIL rate_cn1 got %0d expected 120", cap[0]); end
      if (cap[1] !== 22'd2600) begin errors++; $display("FAIL rate_cn2 got %0d expected 2600", cap[1]); end
    end
  endtask

  task automatic test_abort();
    dec_rate = 1'b1;
    start_run();
    for (int i = 0; i < 5; i++) send_bit(1'b1, -1);
    enable = 1'b0;
    @(posedge clk);
    #1;
    checks += 3;
    if (mclk_out !== 1'b0) begin errors++; $display("FAIL abort_en_mclk got %b expected 0", mclk_out); end
    if (cn_out !== '0) begin errors++; $display("FAIL abort_en_cn got %0d expected 0", cn_out); end
    if (cnr16 !== 1'b0) begin errors++; $display("FAIL abort_en_cnr16 got %b expected 0", cnr16); end
    model_clear();
    repeat (2) @(negedge clk);
    cap.delete();
    start_run();
    for (int i = 0; i < 16; i++) send_bit(1'b1, -1);
    finish_run();
    checks++;
    if (cap.size() != 2 || cap[0] !== 22'd120 || cap[1] !== 22'd816) begin
      errors++;
      $display("FAIL restart_en got %0d frames first %0d expected 2 frames 120,816",
               cap.size(), (cap.size() > 0) ? cap[0] : 22'd0);
    end
    cap.delete();
    start_run();
    for (int i = 0; i < 5; i++) send_bit(1'b1, -1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks += 4;
    if (mclk_out !== 1'b0) begin errors++; $display("FAIL abort_rst_mclk got %b expected 0", mclk_out); end
    if (cn_out !== '0) begin errors++; $display("FAIL abort_rst_cn got %0d expected 0", cn_out); end
    if (cnr16 !== 1'b0) begin errors++; $display("FAIL abort_rst_cnr16 got %b expected 0", cnr16); end
    if (mod_fault !== 1'b0) begin errors++; $display("FAIL abort_rst_fault got %b expected 0", mod_fault); end
    sb.delete();
    @(negedge clk);
    model_clear();
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) send_bit(1'b1, -1);
    finish_run();
    checks++;
    if (cap.size() != 2 || cap[0] !== 22'd120 || cap[1] !== 22'd816) begin
      errors++;
      $display("FAIL restart_rst got %0d frames first %0d expected 2 frames 120,816",
               cap.size(), (cap.size() > 0) ? cap[0] : 22'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_fault();
    test_ones();
    test_mclk();
    test_alternating();
    test_wrap();
    test_rate_change();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
